// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared defs for the data-memory SRAM controller: access-size codes,
// controller state encodings and byte-lane mask helpers.
package dmem_sram_ctrl_pkg;

   localparam logic [2:0] MEM_ACCESS_LENGTH_BYTE       = 3'd0;
   localparam logic [2:0] MEM_ACCESS_LENGTH_HALF       = 3'd1;
   localparam logic [2:0] MEM_ACCESS_LENGTH_WORD       = 3'd2;
   localparam logic [2:0] MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3;
   localparam logic [2:0] MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;

   typedef enum logic [2:0] {
      DMEM_ST_IDLE   = 3'd0,
      DMEM_ST_RD     = 3'd1,
      DMEM_ST_WR     = 3'd2,
      DMEM_ST_WR_REC = 3'd3,
      DMEM_ST_DONE   = 3'd4
   } dmem_state_t;

   // Lanes 0..lo (SWL)
   function automatic logic [3:0] be_left(input logic [1:0] lo);
      logic [4:0] m;
      m = (5'd2 << lo) - 5'd1;
      return m[3:0];
   endfunction

   // Lanes lo..3 (SWR)
   function automatic logic [3:0] be_right(input logic [1:0] lo);
      return 4'b1111 << lo;
   endfunction

endpackage

// File: rtl/dmem_be_gen.sv
// Byte-lane enable generator: maps store size and address low bits to
// active-high lane enables; loads always enable all four lanes.
module dmem_be_gen
   import dmem_sram_ctrl_pkg::*;
(
   input  logic [2:0] req_size,
   input  logic [1:0] req_addr_lo,
   input  logic       req_write,
   output logic [3:0] be
);

   always_comb begin
      be = 4'b1111;
      if (req_write) begin
         unique case (req_size)
            MEM_ACCESS_LENGTH_BYTE:       be = 4'b0001 << req_addr_lo;
            MEM_ACCESS_LENGTH_HALF:       be = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            MEM_ACCESS_LENGTH_WORD:       be = 4'b1111;
            MEM_ACCESS_LENGTH_LEFT_WORD:  be = be_left(req_addr_lo);
            MEM_ACCESS_LENGTH_RIGHT_WORD: be = be_right(req_addr_lo);
            default:                      be = 4'b0000;
         endcase
      end
   end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Data-memory SRAM controller with programmable read/write wait states.
// Optional access/stall statistics counters under `DMEM_STAT_EN.
module dmem_sram_ctrl
   import dmem_sram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 20,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_addr_lo,
   input  logic [2:0]        req_size,
   input  logic [31:0]       req_wdata,
   input  logic              req_align_err,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [31:0]       sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [3:0]        sram_be_n
`ifdef DMEM_STAT_EN
   ,
   output logic [31:0]       stat_rd_cnt,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);

   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CNT_W    = ($clog2(MAX_WAIT) < 1) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

   dmem_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_rdata;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_dq_o;
   logic              r_dq_oe;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic [3:0]        r_be_n;

   logic              w_accept;
   logic [3:0]        w_be;
   logic              w_busy;
   logic              w_unused;

   assign w_unused = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   dmem_be_gen u_be_gen (
      .req_size    (req_size),
      .req_addr_lo (req_addr_lo),
      .req_write   (req_write),
      .be          (w_be)
   );

   assign w_accept = (req_read | req_write) & ~req_align_err;

   assign w_busy = (r_state == DMEM_ST_RD) |
                   (r_state == DMEM_ST_WR) |
                   (r_state == DMEM_ST_WR_REC);

   // Gated by rst so an abort drops the hold even with a request pending.
   assign stall = ~rst & (((r_state == DMEM_ST_IDLE) & w_accept) | w_busy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= DMEM_ST_IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_dq_o  <= '0;
         r_dq_oe <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_be_n  <= 4'hF;
      end else begin
         unique case (r_state)
            DMEM_ST_IDLE: begin
               if (w_accept) begin
                  r_addr <= req_addr[ADDR_W+1:2];
                  r_ce_n <= 1'b0;
                  if (req_write) begin
                     r_state <= DMEM_ST_WR;
                     r_we_n  <= 1'b0;
                     r_dq_oe <= 1'b1;
                     r_dq_o  <= req_wdata;
                     r_be_n  <= ~w_be;
                     r_cnt   <= WR_LOAD;
                  end else begin
                     r_state <= DMEM_ST_RD;
                     r_oe_n  <= 1'b0;
                     r_be_n  <= 4'h0;
                     r_cnt   <= RD_LOAD;
                  end
               end
            end
            DMEM_ST_RD: begin
               if (r_cnt == '0) begin
                  r_rdata <= sram_dq_i;
                  r_state <= DMEM_ST_DONE;
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_be_n  <= 4'hF;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DMEM_ST_WR: begin
               if (r_cnt == '0) begin
                  r_state <= DMEM_ST_WR_REC;
                  r_we_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DMEM_ST_WR_REC: begin
               // Data and lanes held one cycle past the write strobe.
               r_state <= DMEM_ST_DONE;
               r_ce_n  <= 1'b1;
               r_dq_oe <= 1'b0;
               r_be_n  <= 4'hF;
            end
            DMEM_ST_DONE: begin
               r_state <= DMEM_ST_IDLE;
            end
            default: begin
               r_state <= DMEM_ST_IDLE;
            end
         endcase
      end
   end

   assign rdata      = r_rdata;
   assign sram_addr  = r_addr;
   assign sram_dq_o  = r_dq_o;
   assign sram_dq_oe = r_dq_oe;
   assign sram_ce_n  = r_ce_n;
   assign sram_oe_n  = r_oe_n;
   assign sram_we_n  = r_we_n;
   assign sram_be_n  = r_be_n;

`ifdef DMEM_STAT_EN
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if ((r_state == DMEM_ST_RD) && (r_cnt == '0))
            r_rd_cnt <= r_rd_cnt + 32'd1;
         if (r_state == DMEM_ST_WR_REC)
            r_wr_cnt <= r_wr_cnt + 32'd1;
      end
   end

   assign stat_rd_cnt    = r_rd_cnt;
   assign stat_wr_cnt    = r_wr_cnt;
   assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule
